// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with parity, framing, break and overrun status
module uart_rx_param #(
    parameter int FREQUENCY    = 50000000,
    parameter int BAUD         = 115200,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int OVERSAMPLING = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int OS_DEN  = BAUD * OVERSAMPLING;
    localparam int DIV_RND = (FREQUENCY + OS_DEN / 2) / OS_DEN;
    localparam int DIV     = (DIV_RND < 1) ? 1 : DIV_RND;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW      = $clog2(OVERSAMPLING);
    localparam int BW      = $clog2(DATA_BITS);
    localparam int MID     = OVERSAMPLING / 2;

    localparam logic [OW-1:0] OS_S0   = OW'(MID - 1);
    localparam logic [OW-1:0] OS_S1   = OW'(MID);
    localparam logic [OW-1:0] OS_S2   = OW'(MID + 1);
    localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLING - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLING < 8 || OVERSAMPLING > 32 ||
        (OVERSAMPLING & (OVERSAMPLING - 1)) != 0) begin : g_bad_oversampling
        $error("uart_rx_param: OVERSAMPLING must be a power of 2 in 8..32");
    end
    if (BAUD < 1 || FREQUENCY < OS_DEN) begin : g_bad_divider
        $error("uart_rx_param: FREQUENCY too low for BAUD*OVERSAMPLING");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK_WAIT
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [TW-1:0]         r_tick_cnt;
    logic                  w_tick;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  w_rxd;
    logic [OW-1:0]         r_os_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic                  r_stop_cnt;
    logic                  r_samp_a;
    logic                  r_samp_b;
    logic                  w_vote;
    logic                  w_at_vote;
    logic                  w_at_end;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_all_zero;
    logic                  r_perr;
    logic                  r_ferr;
    logic                  w_done;
    logic                  w_break;
    logic [DATA_BITS-1:0]  w_word_data;
    logic                  w_word_ferr;

    assign w_rxd     = r_sync2;
    assign w_tick    = (r_tick_cnt == TW'(DIV - 1));
    assign w_vote    = (r_samp_a & r_samp_b) | (r_samp_a & w_rxd) | (r_samp_b & w_rxd);
    assign w_at_vote = w_tick && (r_os_cnt == OS_S2);
    assign w_at_end  = w_tick && (r_os_cnt == OS_LAST);
    assign rx_busy   = (r_state != S_IDLE);

    // A break reports an all-zero word; the failing stop vote already marks the frame bad.
    assign w_word_data = w_break ? '0 : r_shift;
    assign w_word_ferr = r_ferr | ~w_vote;

    // Two-flop synchronizer on the asynchronous line, idling high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running oversample tick divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus frame completion; completion happens at the last stop bit's vote
    // so a start edge immediately following the stop bit is not missed.
    always_comb begin
        w_next  = r_state;
        w_done  = 1'b0;
        w_break = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick && !w_rxd) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                if (w_at_vote && w_vote) begin
                    w_next = S_IDLE;
                end else if (w_at_end) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_at_end && r_bit_cnt == BW'(DATA_BITS - 1)) begin
                    w_next = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_at_end) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_at_vote) begin
                    if (!r_stop_cnt && r_all_zero && !w_vote) begin
                        w_break = 1'b1;
                        w_done  = 1'b1;
                        w_next  = S_BREAK_WAIT;
                    end else if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                        w_done  = 1'b1;
                        w_next  = S_IDLE;
                    end
                end
            end
            S_BREAK_WAIT: begin
                if (w_rxd) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Per-bit sampling, data shifting and per-frame status accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_samp_a   <= 1'b1;
            r_samp_b   <= 1'b1;
            r_shift    <= '0;
            r_all_zero <= 1'b1;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_all_zero <= 1'b1;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else if (w_tick) begin
            r_os_cnt <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + OW'(1);
            if (r_os_cnt == OS_S0) begin
                r_samp_a <= w_rxd;
            end
            if (r_os_cnt == OS_S1) begin
                r_samp_b <= w_rxd;
            end
            if (r_os_cnt == OS_S2) begin
                case (r_state)
                    S_DATA: begin
                        r_shift    <= {w_vote, r_shift[DATA_BITS-1:1]};
                        r_all_zero <= r_all_zero & ~w_vote;
                    end
                    S_PARITY: begin
                        r_all_zero <= r_all_zero & ~w_vote;
                        if (PARITY == 1) begin
                            r_perr <= (^r_shift) ^ w_vote;
                        end else begin
                            r_perr <= ~((^r_shift) ^ w_vote);
                        end
                    end
                    S_STOP: begin
                        if (!w_vote) begin
                            r_ferr <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            if (r_os_cnt == OS_LAST) begin
                if (r_state == S_DATA) begin
                    r_bit_cnt <= r_bit_cnt + BW'(1);
                end
                if (r_state == S_STOP) begin
                    r_stop_cnt <= 1'b1;
                end
            end
        end
    end

    // Output word holding register with valid/ready handshake and sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else if (w_done) begin
            if (!rx_valid || rx_ready) begin
                rx_data    <= w_word_data;
                rx_valid   <= 1'b1;
                parity_err <= r_perr;
                frame_err  <= w_word_ferr;
                break_det  <= w_break;
                if (rx_valid) begin
                    overrun <= 1'b0;
                end
            end else begin
                overrun <= 1'b1;
            end
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param (8N1, 8E1, 8O1 at DIV=1)
module tb_uart_rx_param;

    localparam int FREQ = 1843200;
    localparam int BR   = 115200;
    localparam int OSR  = 16;
    localparam int BITC = 16;

    typedef struct {
        int         s;
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } word_t;

    typedef struct {
        int         s;
        logic [7:0] din;
        logic       pflip;
        logic       stopv;
        logic [7:0] ed;
        logic       epe;
        logic       efe;
        logic       ebk;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line = 1'b1;
    logic       rdy = 1'b1;
    int         sel = 0;
    logic [2:0] rxd_v;
    logic [7:0] d [3];
    logic [2:0] v, pe, fe, bk, ov, busy;

    int    checks = 0;
    int    failures = 0;
    word_t got[$];
    int    vcnt[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign rxd_v[g] = (sel == g) ? line : 1'b1;
        uart_rx_param #(
            .FREQUENCY(FREQ), .BAUD(BR), .DATA_BITS(8), .PARITY(g),
            .STOP_BITS(1), .OVERSAMPLING(OSR)
        ) u_dut (
            .clk(clk), .rst(rst), .rxd(rxd_v[g]),
            .rx_data(d[g]), .rx_valid(v[g]), .rx_ready(rdy),
            .parity_err(pe[g]), .frame_err(fe[g]), .break_det(bk[g]),
            .overrun(ov[g]), .rx_busy(busy[g])
        );
    end

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (v[g]) begin
                word_t w;
                vcnt[g]++;
                if (rdy) begin
                    w.s = g; w.d = d[g]; w.pe = pe[g]; w.fe = fe[g]; w.bk = bk[g];
                    got.push_back(w);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic line_parity(input int s, input logic [7:0] data, input logic pflip);
        logic ones_odd;
        ones_odd = ($countones(data) % 2) == 1;
        if (s == 1) return ones_odd ^ pflip;
        return (!ones_odd) ^ pflip;
    endfunction

    function automatic word_t model(input int s, input logic [7:0] data, input logic pflip,
                                    input logic stopv);
        word_t w;
        logic  pb;
        int    ones;
        logic  brk;
        pb   = (s != 0) ? line_parity(s, data, pflip) : 1'b1;
        ones = $countones(data) + int'(pb && s != 0);
        brk  = (data == 8'h00) && (s == 0 || pb == 1'b0) && (stopv == 1'b0);
        w.s  = s;
        w.d  = brk ? 8'h00 : data;
        w.pe = (s == 1) ? (ones % 2 != 0) : (s == 2) ? (ones % 2 == 0) : 1'b0;
        w.fe = (stopv == 1'b0);
        w.bk = brk;
        return w;
    endfunction

    task automatic bit_out(input logic b);
        line = b;
        repeat (BITC) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        line = 1'b1;
        repeat (n * BITC) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int s, input logic [7:0] data, input logic pflip,
                              input logic stopv);
        sel = s;
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(data[i]);
        if (s != 0) bit_out(line_parity(s, data, pflip));
        bit_out(stopv);
    endtask

    task automatic expect_word(input string tag, input word_t m);
        word_t w;
        chk({tag, "_count"}, got.size(), 1);
        if (got.size() > 0) begin
            w = got.pop_front();
            chk({tag, "_dut"}, w.s, m.s);
            chk({tag, "_data"}, w.d, m.d);
            chk({tag, "_perr"}, w.pe, m.pe);
            chk({tag, "_ferr"}, w.fe, m.fe);
            chk({tag, "_brk"}, w.bk, m.bk);
        end
        got.delete();
    endtask

    vec_t tbl[7];

    initial begin
        word_t m;
        int    v0;
        logic  saw_busy;

        tbl[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{2, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{2, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", {v, pe, fe, bk, ov, busy}, 0);
        chk("rst_data", {d[0], d[1], d[2]}, 0);
        rst = 1'b0;
        idle_bits(2);

        foreach (tbl[i]) begin
            v0 = vcnt[tbl[i].s];
            send_frame(tbl[i].s, tbl[i].din, tbl[i].pflip, tbl[i].stopv);
            idle_bits(2);
            m.s = tbl[i].s; m.d = tbl[i].ed; m.pe = tbl[i].epe; m.fe = tbl[i].efe; m.bk = tbl[i].ebk;
            expect_word($sformatf("vec%0d", i), m);
            chk($sformatf("vec%0d_pulse", i), vcnt[tbl[i].s] - v0, 1);
        end

        sel = 0;
        for (int i = 0; i < 20; i++) bit_out(1'b0);
        chk("brk_busy_low", busy[0], 1'b1);
        m.s = 0; m.d = 8'h00; m.pe = 1'b0; m.fe = 1'b1; m.bk = 1'b1;
        expect_word("brk", m);
        line = 1'b1;
        for (int i = 0; i < 40 && busy[0]; i++) begin
            @(posedge clk);
            #1;
        end
        chk("brk_busy_release", busy[0], 1'b0);
        idle_bits(2);
        chk("brk_no_more", got.size(), 0);

        rdy = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1);
        idle_bits(1);
        chk("ovr_valid", v[0], 1'b1);
        chk("ovr_data", d[0], 8'h11);
        chk("ovr_flag", ov[0], 1'b1);
        rdy = 1'b1;
        @(posedge clk);
        #1;
        rdy = 1'b0;
        chk("ovr_hs_valid", v[0], 1'b0);
        chk("ovr_hs_flag", ov[0], 1'b0);
        chk("ovr_hs_count", got.size(), 1);
        if (got.size() > 0) chk("ovr_hs_data", got[0].d, 8'h11);
        got.delete();
        rdy = 1'b1;
        idle_bits(1);

        sel = 0;
        v0 = vcnt[0];
        line = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        line = 1'b1;
        saw_busy = busy[0];
        for (int i = 0; i < 16 && busy[0]; i++) begin
            @(posedge clk);
            #1;
            saw_busy = saw_busy | busy[0];
        end
        chk("glitch_started", saw_busy, 1'b1);
        chk("glitch_busy_clear", busy[0], 1'b0);
        idle_bits(2);
        chk("glitch_no_valid", vcnt[0] - v0, 0);

        sel = 0;
        bit_out(1'b0);
        for (int i = 0; i < 3; i++) bit_out(1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {v, pe, fe, bk, ov, busy}, 0);
        chk("midrst_data", d[0], 8'h00);
        @(posedge clk);
        #1;
        line = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_bits(1);
        got.delete();
        send_frame(0, 8'h5A, 1'b0, 1'b1);
        idle_bits(2);
        m.s = 0; m.d = 8'h5A; m.pe = 1'b0; m.fe = 1'b0; m.bk = 1'b0;
        expect_word("midrst", m);

        for (int i = 0; i < 24; i++) begin
            int         s;
            logic [7:0] data;
            logic       pflip, stopv;
            s     = $urandom_range(0, 2);
            data  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) data = 8'h00;
            pflip = ($urandom_range(0, 3) == 0);
            stopv = ($urandom_range(0, 4) != 0);
            send_frame(s, data, pflip, stopv);
            idle_bits(2);
            expect_word($sformatf("rnd%0d", i), model(s, data, pflip, stopv));
        end
        chk("end_overrun", ov, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
